// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned ENTRY_W = ERR_W + DATA_W;

  // Receiver error codes, stored per entry but not interpreted here.
  localparam logic [ERR_W-1:0] ERR_NONE    = 3'b000;
  localparam logic [ERR_W-1:0] ERR_PARITY  = 3'b001;
  localparam logic [ERR_W-1:0] ERR_FRAMING = 3'b010;
  localparam logic [ERR_W-1:0] ERR_OVERRUN = 3'b100;

  // Receiver handshake states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // One FIFO entry: error code in the upper bits, byte in the lower bits.
  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through FIFO with separate occupancy count.
module uart_rx_fifo_sync_fifo #(
  parameter int unsigned W      = 11,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              avail
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next_c;
  logic              do_pop_c;
  logic              do_push_c;

  // Pops only from a non-empty FIFO; a push into a full FIFO needs a same-cycle pop.
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  // Head entry is always visible on the read port.
  assign rdata = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_c = count;
    case ({do_push_c, do_pop_c})
      2'b10:   count_next_c = count + (ADDR_W+1)'(1);
      2'b01:   count_next_c = count - (ADDR_W+1)'(1);
      default: count_next_c = count;
    endcase
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      avail  <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next_c;
      empty <= (count_next_c == '0);
      full  <= (count_next_c == (ADDR_W+1)'(DEPTH));
      avail <= (count_next_c != '0);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: irq synchroniser, capture/ack handshake and byte FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic [2:0]        rx_err,
  input  logic              rx_irq,
  output logic              rx_ack,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [2:0]        rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              data_irq
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_s;
  state_t                 state;
  state_t                 state_next;
  logic                   push_c;
  logic                   ack_next_c;
  logic                   drop_c;
  entry_t                 wr_entry;
  entry_t                 rd_entry;

  // Multi-flop synchroniser for the asynchronous request.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_irq};
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one capture per request, wait in ACK for it to drop.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (irq_s)  state_next = ST_ACK;
      ST_ACK:  if (!irq_s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: push on capture, acknowledge held while request is high.
  always_comb begin
    push_c     = 1'b0;
    ack_next_c = 1'b0;
    case (state)
      ST_IDLE: begin
        push_c     = irq_s;
        ack_next_c = irq_s;
      end
      ST_ACK:  ack_next_c = irq_s;
      default: ack_next_c = 1'b0;
    endcase
  end

  // Acknowledge register; asserted even when the byte is dropped.
  always_ff @(posedge clk) begin
    if (reset) rx_ack <= 1'b0;
    else       rx_ack <= ack_next_c;
  end

  // A full FIFO only accepts a push when the host pops in the same cycle.
  assign drop_c = push_c & full & ~rd_en;

  // Sticky overflow flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (drop_c)       overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign wr_entry = '{err: rx_err, data: rx_data};

  uart_rx_fifo_sync_fifo #(
    .W      (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (rd_en),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .empty (empty),
    .full  (full),
    .avail (data_irq)
  );

  assign rd_data = rd_entry.data;
  assign rd_err  = rd_entry.err;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It synchronises the receiver's host_interrupt, captures each received byte and its 3-bit error code, and returns the acknowledge pulse the receiver waits on. Captured bytes go into a FIFO, so the host can read them in bursts instead of servicing every byte. Sits between the UART top-level receive outputs and the host bus.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two.
ADDR_W, 4, log2(DEPTH).
SYNC_STAGES, 2, flip-flop stages on rx_irq (minimum 2).

Ports:
clk  in  1  single system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  received byte from the receiver; stable while rx_irq is high.
rx_err  in  3  receiver error code; stable while rx_irq is high.
rx_irq  in  1  receiver byte-ready request (receiver host_interrupt); treated as asynchronous.
rx_ack  out  1  acknowledge to the receiver (drives host_aknowledged).
rd_en  in  1  host pop request.
rd_data  out  8  head-entry byte (first-word fall-through).
rd_err  out  3  head-entry error code.
empty  out  1  FIFO empty.
full  out  1  FIFO holds DEPTH entries.
count  out  ADDR_W+1  number of entries, 0..DEPTH.
overflow  out  1  sticky flag: a byte was dropped.
clr_overflow  in  1  clears overflow.
data_irq  out  1  host interrupt, equal to !empty.

Behaviour:
- Reset is synchronous. On reset: rx_ack=0, count=0, empty=1, full=0, overflow=0, data_irq=0, pointers=0, synchroniser cleared, FSM=IDLE. Memory contents are don't-care.
- rx_irq passes through SYNC_STAGES flops. irq_s is the final stage. rx_data and rx_err are sampled only in the capture cycle.
- FSM IDLE: if irq_s=1, then capture: push {rx_err,rx_data}, set rx_ack<=1, go to ACK.
- FSM ACK: hold rx_ack=1 while irq_s=1. When irq_s=0, set rx_ack<=0 and go to IDLE. A new byte is never captured in ACK. Each rx_irq assertion yields exactly one push.
- Latency with SYNC_STAGES=2: rx_irq rises before edge n. The push and rx_ack rise are visible after edge n+2. empty falls and count increments on that same edge.
- FIFO is first-word fall-through. rd_data and rd_err always show the entry at rd_ptr, so they are valid whenever empty=0. When empty=1 they hold their last value and are don't-care.
- Pop occurs when rd_en=1 and empty=0. rd_en while empty is ignored: no pointer change, no error.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is tracked separately.
  - full = (count==DEPTH).
  - empty = (count==0).
- Push and pop in the same cycle, non-empty: both happen and count is unchanged.
- Push while empty with rd_en=1: the pop is ignored because empty=1 at that edge. The push takes effect.
- Push while full:
  - With a same-cycle pop: pop then push, count stays DEPTH, no overflow.
  - Without a pop: the byte is dropped and overflow<=1. rx_ack is still asserted so the receiver never stalls.
- overflow is cleared by clr_overflow. If set and clear occur in the same cycle, set wins.
- Reset mid-handshake (in ACK): rx_ack drops, FSM goes to IDLE, FIFO is emptied. If rx_irq is still high after reset, that byte is captured again, after the synchroniser latency. This is required behaviour.
- rx_err is stored per entry and not interpreted. A non-zero error code does not block the push.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, ACK) and the entry width constant ENTRY_W=11 (3 error + 8 data). It also holds error-code constants for use by the receiver and this block.
- One natural sub-module: sync_fifo (parameterised width/depth storage, pointers, count, full/empty). The handshake FSM and synchroniser stay in the top module.

Test Plan:
1. Reset, then one byte: rx_data=0xA5, rx_err=0, rx_irq held high until rx_ack, then dropped. Expect exactly one rx_ack pulse, count=1, rd_data=0xA5, data_irq=1. rd_en for one cycle gives count=0, empty=1.
2. rx_irq held high for 20 cycles. Expect exactly one push (count=1) and rx_ack high until 2 cycles after rx_irq falls.
3. Write 16 bytes 0x00..0x0F, then a 17th byte 0xFF with no reads. Expect full=1, count=16, overflow=1, 0xFF absent. Reading 16 times returns 0x00..0x0F in order, then empty=1. clr_overflow clears the flag.
4. FIFO full, capture 0x55 with rd_en=1 in the capture cycle. Expect overflow=0, count=16, and the last entry read out is 0x55.
5. Byte with rx_err=3'b010, data 0x3C. Expect rd_err=3'b010 and rd_data=0x3C at the head.
6. Reset asserted while in ACK with rx_irq still high. Expect rx_ack=0 and count=0 after the reset edge, then re-capture (count=1) 3 edges after reset deasserts.
